mips_imem_loader: RTL and testbench
===================================

Name: mips_imem_loader

Overview:
- Reverse of the main decoder: takes a symbolic instruction (kind plus register/immediate fields), encodes it into a 32-bit MIPS word using the same opcode set (RTYPE, LW, SW, BEQ, BNE, ADDI, J), and writes it sequentially into instruction memory.
- Sits between a testbench or boot source and the single-cycle core's instruction memory write port.
- Ready/valid input, one output register stage with memory back-pressure, an address counter and a run FSM.

Parameters:
- ADDR_W, 32, byte-address width of the memory write port.
- DEPTH, 64, maximum words per load session.
- BASE_ADDR, 0, byte address of the first word.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins a load session.
- in_valid  in  1  instruction request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_kind  in  3  0 RTYPE, 1 LW, 2 SW, 3 BEQ, 4 BNE, 5 ADDI, 6 J, 7 illegal.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields.
- in_funct  in  6  RTYPE function code.
- in_imm  in  16  immediate / branch offset.
- in_target  in  26  jump target.
- in_last  in  1  marks the final instruction of the session.
- mem_we  out  1  write strobe; held until mem_ready.
- mem_ready  in  1  memory accepts the write this cycle.
- mem_addr  out  ADDR_W  byte address, word aligned.
- mem_wdata  out  32  encoded instruction.
- count  out  $clog2(DEPTH+1)  words written this session.
- done  out  1  one-cycle pulse at session end.
- err  out  1  sticky; set on illegal kind or overflow.

Behaviour:
- Reset: state IDLE; in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, done=0, err=0.
- FSM IDLE -> RUN on start: clear count and err, load the address pointer with BASE_ADDR.
- RUN -> DRAIN when an in_last beat is accepted.
- DRAIN -> DONE when the pending write completes (mem_we && mem_ready).
- DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored outside IDLE.
- Encoding:
  - RTYPE = {000000, rs, rt, rd, shamt, funct}.
  - LW 100011, SW 101011, BEQ 000100, BNE 000101, ADDI 001000 = {op, rs, rt, imm}.
  - J = {000010, target}.
- in_ready = (state==RUN) && (!mem_we || mem_ready) && (accepted < DEPTH), where accepted = count plus the in-flight word.
- Latency: an accepted beat drives mem_we and mem_wdata on the next cycle. Back-to-back writes run at 1 per cycle while mem_ready=1.
- mem_we, mem_addr and mem_wdata stay stable while mem_we && !mem_ready.
- On each completed write: count+1 and mem_addr+4. The address wraps modulo 2^ADDR_W.
- Illegal kind (7):
  - The beat is consumed, no write is issued, err is set.
  - If in_last is set on that beat, the FSM still moves to DRAIN, or straight to DONE if nothing is pending.
- Overflow: accepted==DEPTH in RUN drops in_ready. If in_valid is held in that state, err is set. A session ends only via in_last.
- Simultaneous accept and write completion in the same cycle: the output register reloads with the new word and the address advances by exactly 4.
- Reset mid-session: returns to IDLE immediately and any pending write is dropped.

Decomposition:
- Shared package mips_pkg:
  - instr_kind_e enum (3-bit).
  - Opcode localparams: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J (the decoder uses the same constants).
  - loader_state_e.
- Sub-module mips_instr_encode: purely combinational kind/fields -> {word, illegal}.

Test Plan:
- start; ADDI rs=0 rt=8 imm=5 with in_last -> one write, addr 0x0, data 0x20080005; done pulse; count=1.
- LW rs=8 rt=9 imm=4, then RTYPE rs=8 rt=9 rd=10 funct=0x20, then J target=0x10 (last), mem_ready=1 -> data 0x8D090004, 0x01095020, 0x08000010 at addr 0x0, 0x4, 0x8 on consecutive cycles.
- BEQ rs=1 rt=2 imm=0xFFFF with mem_ready low 3 cycles -> mem_we held, data 0x1022FFFF stable, in_ready=0 until accepted.
- kind=7 between two ADDI beats -> err=1, only 2 writes, at 0x0 and 0x4.
- DEPTH=4, stream 6 beats -> 4 writes, in_ready low afterwards, err=1.
- reset_n low mid-stream -> all outputs return to reset values; a new start writes from BASE_ADDR again.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction kinds, primary opcodes and loader FSM states.
package mips_pkg;

  typedef enum logic [2:0] {
    KIND_RTYPE   = 3'd0,
    KIND_LW      = 3'd1,
    KIND_SW      = 3'd2,
    KIND_BEQ     = 3'd3,
    KIND_BNE     = 3'd4,
    KIND_ADDI    = 3'd5,
    KIND_J       = 3'd6,
    KIND_ILLEGAL = 3'd7
  } instr_kind_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/mips_instr_encode.sv
// Combinational encoder: symbolic instruction kind plus fields -> 32-bit MIPS word.
module mips_instr_encode
  import mips_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (instr_kind_e'(kind))
      KIND_RTYPE: word = {OP_RTYPE, rs, rt, rd, shamt, funct};
      KIND_LW:    word = {OP_LW, rs, rt, imm};
      KIND_SW:    word = {OP_SW, rs, rt, imm};
      KIND_BEQ:   word = {OP_BEQ, rs, rt, imm};
      KIND_BNE:   word = {OP_BNE, rs, rt, imm};
      KIND_ADDI:  word = {OP_ADDI, rs, rt, imm};
      KIND_J:     word = {OP_J, target};
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_imem_loader.sv
// Encodes a stream of symbolic instructions and writes them sequentially into
// instruction memory through a single back-pressured output register.
module mips_imem_loader
  import mips_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DEPTH     = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0]                   in_kind,
  input  logic [4:0]                   in_rs,
  input  logic [4:0]                   in_rt,
  input  logic [4:0]                   in_rd,
  input  logic [4:0]                   in_shamt,
  input  logic [5:0]                   in_funct,
  input  logic [15:0]                  in_imm,
  input  logic [25:0]                  in_target,
  input  logic                         in_last,
  output logic                         mem_we,
  input  logic                         mem_ready,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [31:0]                  mem_wdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         done,
  output logic                         err
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned ACC_W = CNT_W + 1;

  loader_state_e     state;
  logic [31:0]       enc_word;
  logic              enc_illegal;
  logic [ACC_W-1:0]  accepted;
  logic              room;
  logic              accept;
  logic              complete;

  mips_instr_encode u_encode (
    .kind    (in_kind),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .shamt   (in_shamt),
    .funct   (in_funct),
    .imm     (in_imm),
    .target  (in_target),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  // Words already written plus the one sitting in the output register.
  assign accepted = ACC_W'(count) + ACC_W'(mem_we);
  assign room     = accepted < ACC_W'(DEPTH);
  assign in_ready = (state == ST_RUN) && (!mem_we || mem_ready) && room;
  assign accept   = in_valid && in_ready;
  assign complete = mem_we && mem_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
      count     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;

      if (complete) begin
        count    <= count + CNT_W'(1);
        mem_addr <= mem_addr + ADDR_W'(4);
      end

      // A new word reloads the register even when the previous one retires this cycle.
      if (accept && !enc_illegal) begin
        mem_we    <= 1'b1;
        mem_wdata <= enc_word;
      end else if (complete) begin
        mem_we <= 1'b0;
      end

      if ((accept && enc_illegal) || (state == ST_RUN && in_valid && !room)) begin
        err <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_RUN;
            count    <= '0;
            err      <= 1'b0;
            mem_addr <= BASE_ADDR;
          end
        end
        ST_RUN: begin
          if (accept && in_last) begin
            if (!enc_illegal || (mem_we && !mem_ready)) begin
              state <= ST_DRAIN;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (complete || !mem_we) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_imem_loader.sv
// Randomized self-checking bench for mips_imem_loader against a transaction-level model.
module tb_mips_imem_loader;

  typedef struct packed {
    logic [2:0]  kind;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic reset_n, st, sel, in_valid, in_last, mem_ready;
  logic start_a, start_b;
  logic [2:0]  in_kind;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;

  logic        rdy_a, we_a, done_a, err_a, rdy_b, we_b, done_b, err_b;
  logic [31:0] addr_a, data_a, addr_b, data_b;
  logic [6:0]  count_a;
  logic [2:0]  count_b;

  logic        o_rdy, o_we, o_done, o_err;
  logic [31:0] o_addr, o_data;
  int          o_cnt;

  int n_chk = 0, n_bad = 0;

  // model state
  beat_t       beats[$];
  logic [31:0] wq[$], wlog[$], alog[$];
  int          depth, cnt, pend, force_stall;
  logic [31:0] base, exp_addr, p_addr, p_data;
  bit          m_run, m_err, last_acc, exp_done, hold_prev, saw_done;

  always #5 clk = ~clk;

  assign start_a = st && !sel;
  assign start_b = st && sel;

  mips_imem_loader u_dut (
    .clk(clk), .reset_n(reset_n), .start(start_a), .in_valid(in_valid), .in_ready(rdy_a),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .mem_we(we_a), .mem_ready(mem_ready), .mem_addr(addr_a), .mem_wdata(data_a),
    .count(count_a), .done(done_a), .err(err_a)
  );

  mips_imem_loader #(.DEPTH(4), .BASE_ADDR(32'hFFFF_FFF8)) u_small (
    .clk(clk), .reset_n(reset_n), .start(start_b), .in_valid(in_valid), .in_ready(rdy_b),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .mem_we(we_b), .mem_ready(mem_ready), .mem_addr(addr_b), .mem_wdata(data_b),
    .count(count_b), .done(done_b), .err(err_b)
  );

  always_comb begin
    o_rdy  = sel ? rdy_b  : rdy_a;
    o_we   = sel ? we_b   : we_a;
    o_done = sel ? done_b : done_a;
    o_err  = sel ? err_b  : err_a;
    o_addr = sel ? addr_b : addr_a;
    o_data = sel ? data_b : data_a;
    o_cnt  = sel ? int'(count_b) : int'(count_a);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // MIPS encoding straight from the opcode table.
  function automatic logic [31:0] ref_enc(input beat_t b);
    case (b.kind)
      3'd0:    return {6'h00, b.rs, b.rt, b.rd, b.shamt, b.funct};
      3'd1:    return {6'h23, b.rs, b.rt, b.imm};
      3'd2:    return {6'h2B, b.rs, b.rt, b.imm};
      3'd3:    return {6'h04, b.rs, b.rt, b.imm};
      3'd4:    return {6'h05, b.rs, b.rt, b.imm};
      3'd5:    return {6'h08, b.rs, b.rt, b.imm};
      3'd6:    return {6'h02, b.target};
      default: return 32'h0;
    endcase
  endfunction

  function automatic beat_t mk(input int k, input int rs, input int rt, input int rd,
                               input int funct, input int imm, input int tgt, input bit last);
    beat_t b;
    b.kind = 3'(k); b.rs = 5'(rs); b.rt = 5'(rt); b.rd = 5'(rd); b.shamt = 5'd0;
    b.funct = 6'(funct); b.imm = 16'(imm); b.target = 26'(tgt); b.last = last;
    return b;
  endfunction

  function automatic beat_t rand_beat(input bit last, input bit allow_ill);
    beat_t b;
    b.kind = (allow_ill && $urandom_range(9) == 0) ? 3'd7 : 3'($urandom_range(6));
    b.rs = 5'($urandom); b.rt = 5'($urandom); b.rd = 5'($urandom); b.shamt = 5'($urandom);
    b.funct = 6'($urandom); b.imm = 16'($urandom); b.target = 26'($urandom); b.last = last;
    return b;
  endfunction

  task automatic model_reset();
    beats.delete(); wq.delete();
    m_run = 0; m_err = 0; last_acc = 0; exp_done = 0; hold_prev = 0;
    cnt = 0; pend = 0; force_stall = 0; exp_addr = base;
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready", o_rdy, 0);
    chk("rst_mem_we", o_we, 0);
    chk("rst_mem_addr", o_addr, base);
    chk("rst_mem_wdata", o_data, 0);
    chk("rst_count", o_cnt, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; in_valid = 1'b0; st = 1'b0; mem_ready = 1'b0;
    #1;
    chk_reset_vals();
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One clock cycle: drive, compare against the model, then advance the model.
  task automatic step(input int stall_pct, input int gap_pct, input bit do_start);
    bit acc, cmp, legal, ovf, idle;
    beat_t b;
    @(negedge clk);
    st = do_start || (m_run && $urandom_range(99) < 5);
    mem_ready = (force_stall > 0) ? 1'b0 : ($urandom_range(99) >= stall_pct);
    in_valid = 1'b0;
    if (beats.size() > 0 && $urandom_range(99) >= gap_pct) begin
      b = beats[0];
      in_kind = b.kind; in_rs = b.rs; in_rt = b.rt; in_rd = b.rd; in_shamt = b.shamt;
      in_funct = b.funct; in_imm = b.imm; in_target = b.target; in_last = b.last;
      in_valid = 1'b1;
    end
    #1;
    if (hold_prev) begin
      chk("hold_addr", o_addr, p_addr);
      chk("hold_data", o_data, p_data);
    end
    chk("mem_we", o_we, pend > 0);
    chk("count", o_cnt, cnt);
    chk("err", o_err, m_err);
    chk("done", o_done, exp_done);
    chk("in_ready", o_rdy, m_run && (pend == 0 || mem_ready) && (cnt + pend < depth));
    if (exp_done) saw_done = 1;
    idle = !m_run && !last_acc && pend == 0 && !exp_done;
    acc = in_valid && o_rdy;
    cmp = (pend > 0) && mem_ready;
    ovf = m_run && in_valid && (cnt + pend >= depth);
    hold_prev = (pend > 0) && !mem_ready;
    p_addr = o_addr; p_data = o_data;
    if (force_stall > 0 && pend > 0) force_stall--;
    if (cmp) begin
      chk("mem_addr", o_addr, exp_addr);
      chk("mem_wdata", o_data, wq[0]);
      wlog.push_back(o_data); alog.push_back(o_addr);
      wq.delete(0);
      cnt++; pend--; exp_addr += 32'd4;
    end
    exp_done = 0;
    if (ovf) m_err = 1;
    if (acc) begin
      b = beats[0];
      beats.delete(0);
      legal = (b.kind != 3'd7);
      if (legal) begin wq.push_back(ref_enc(b)); pend++; end
      else m_err = 1;
      if (b.last) begin m_run = 0; last_acc = 1; end
    end
    if (last_acc && pend == 0) begin last_acc = 0; exp_done = 1; end
    if (st && idle) begin m_run = 1; cnt = 0; m_err = 0; exp_addr = base; end
  endtask

  task automatic session(input int stall_pct, input int gap_pct);
    wlog.delete(); alog.delete(); saw_done = 0;
    step(stall_pct, gap_pct, 1'b1);
    for (int i = 0; i < 400 && !saw_done; i++) step(stall_pct, gap_pct, 1'b0);
    if (!saw_done) chk("session_timeout", 0, 1);
    step(stall_pct, gap_pct, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; st = 1'b0; sel = 1'b0; in_valid = 1'b0; in_last = 1'b0; mem_ready = 1'b0;
    in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
    in_funct = '0; in_imm = '0; in_target = '0;
    depth = 64; base = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // single ADDI
    beats.push_back(mk(5, 0, 8, 0, 0, 5, 0, 1));
    session(0, 0);
    chk("addi_data", wlog[0], 32'h2008_0005);
    chk("addi_addr", alog[0], 32'h0);
    chk("addi_count", o_cnt, 1);

    // back-to-back LW, RTYPE, J
    beats.push_back(mk(1, 8, 9, 0, 0, 4, 0, 0));
    beats.push_back(mk(0, 8, 9, 10, 6'h20, 0, 0, 0));
    beats.push_back(mk(6, 0, 0, 0, 0, 0, 26'h10, 1));
    session(0, 0);
    chk("lw_data", wlog[0], 32'h8D09_0004);
    chk("rtype_data", wlog[1], 32'h0109_5020);
    chk("j_data", wlog[2], 32'h0800_0010);
    chk("j_addr", alog[2], 32'h8);

    // BEQ under 3 cycles of back-pressure
    force_stall = 3;
    beats.push_back(mk(3, 1, 2, 0, 0, 16'hFFFF, 0, 0));
    beats.push_back(mk(5, 3, 4, 0, 0, 7, 0, 1));
    session(0, 0);
    chk("beq_data", wlog[0], 32'h1022_FFFF);

    // illegal kind between two ADDIs
    beats.push_back(mk(5, 1, 1, 0, 0, 1, 0, 0));
    beats.push_back(mk(7, 0, 0, 0, 0, 0, 0, 0));
    beats.push_back(mk(5, 2, 2, 0, 0, 2, 0, 1));
    session(20, 10);
    chk("ill_err", o_err, 1);
    chk("ill_writes", wlog.size(), 2);
    chk("ill_addr1", alog[1], 32'h4);

    // illegal last beat with nothing pending
    beats.push_back(mk(7, 0, 0, 0, 0, 0, 0, 1));
    session(0, 0);
    chk("ill_last_count", o_cnt, 0);

    // random sessions
    for (int s = 0; s < 10; s++) begin
      int n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) beats.push_back(rand_beat(i == n - 1, 1'b1));
      session($urandom_range(60), $urandom_range(30));
    end

    // reset mid-session, then restart from the base address
    for (int i = 0; i < 8; i++) beats.push_back(rand_beat(i == 7, 1'b0));
    step(50, 0, 1'b1);
    repeat (4) step(50, 0, 1'b0);
    do_reset();
    beats.push_back(mk(5, 0, 8, 0, 0, 5, 0, 1));
    session(0, 0);
    chk("post_rst_addr", alog[0], 32'h0);

    // small instance: address wrap and overflow
    sel = 1'b1; depth = 4; base = 32'hFFFF_FFF8;
    do_reset();
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 4; i++) beats.push_back(rand_beat(i == 3, 1'b0));
      session($urandom_range(40), 0);
      chk("wrap_addr2", alog[2], 32'h0);
    end
    for (int i = 0; i < 6; i++) beats.push_back(rand_beat(i == 5, 1'b0));
    step(0, 0, 1'b1);
    repeat (20) step(30, 0, 1'b0);
    chk("ovf_count", o_cnt, 4);
    chk("ovf_err", o_err, 1);
    chk("ovf_in_ready", o_rdy, 0);
    do_reset();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
